// File: rtl/rs_station_pkg.sv
// Shared sizes, entry layout and the broadcast-snoop helper for the reservation station.
package rs_station_pkg;
  localparam int REG_DAT_W   = 32;
  localparam int ROB_ADD_W   = 4;
  localparam int INS_OP_W    = 6;
  localparam int RS_S        = 16;
  localparam int RS_ADD_W    = 4;
  localparam int FULL_MARGIN = 2;
  localparam int CNT_W       = RS_ADD_W + 1;

  typedef logic [CNT_W-1:0] rs_cnt_t;

  typedef struct packed {
    logic                 busy;
    logic [INS_OP_W-1:0]  op;
    logic [REG_DAT_W-1:0] pc;
    logic [REG_DAT_W-1:0] imm;
    logic [ROB_ADD_W-1:0] qs1;
    logic [ROB_ADD_W-1:0] qs2;
    logic [REG_DAT_W-1:0] vs1;
    logic [REG_DAT_W-1:0] vs2;
    logic [ROB_ADD_W-1:0] qd;
  } rs_entry_t;

  // One source operand: tag (0 = value present) and value.
  typedef struct packed {
    logic [ROB_ADD_W-1:0] q;
    logic [REG_DAT_W-1:0] v;
  } rs_src_t;

  // Capture a pending source from the result buses; EX wins if both match.
  function automatic rs_src_t snoop(
    input rs_src_t              s,
    input logic                 ex_en,
    input logic [ROB_ADD_W-1:0] ex_qd,
    input logic [REG_DAT_W-1:0] ex_vd,
    input logic                 lsb_en,
    input logic [ROB_ADD_W-1:0] lsb_qd,
    input logic [REG_DAT_W-1:0] lsb_vd
  );
    rs_src_t r;
    r = s;
    if (s.q != '0) begin
      if (ex_en && ex_qd == s.q) begin
        r.q = '0;
        r.v = ex_vd;
      end else if (lsb_en && lsb_qd == s.q) begin
        r.q = '0;
        r.v = lsb_vd;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/rs_station_pick.sv
// Lowest-index-first priority encoder: index of the first set bit plus a found flag.
module rs_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_found
);
  // Scan high to low so the lowest set bit is the last to overwrite.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = W'(i);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rs_station.sv
// Reservation station: buffers dispatched ALU/branch/jump ops, snoops EX/LSB
// results for wakeup and issues the lowest-index ready entry each cycle.
module rs_station
  import rs_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iMp,
  input  logic                 iROB_En,
  input  logic [INS_OP_W-1:0]  iROB_Op,
  input  logic [REG_DAT_W-1:0] iROB_Pc,
  input  logic [REG_DAT_W-1:0] iROB_Imm,
  input  logic [ROB_ADD_W-1:0] iROB_Qs1,
  input  logic [ROB_ADD_W-1:0] iROB_Qs2,
  input  logic [REG_DAT_W-1:0] iROB_Vs1,
  input  logic [REG_DAT_W-1:0] iROB_Vs2,
  input  logic [ROB_ADD_W-1:0] iROB_Qd,
  input  logic                 iEX_En,
  input  logic [ROB_ADD_W-1:0] iEX_Qd,
  input  logic [REG_DAT_W-1:0] iEX_Vd,
  input  logic                 iLSB_En,
  input  logic [ROB_ADD_W-1:0] iLSB_Qd,
  input  logic [REG_DAT_W-1:0] iLSB_Vd,
  output logic                 oEX_En,
  output logic [INS_OP_W-1:0]  oEX_Op,
  output logic [REG_DAT_W-1:0] oEX_Pc,
  output logic [REG_DAT_W-1:0] oEX_Imm,
  output logic [REG_DAT_W-1:0] oEX_Vs1,
  output logic [REG_DAT_W-1:0] oEX_Vs2,
  output logic [ROB_ADD_W-1:0] oEX_Qd,
  output logic                 oIF_Full
);
  rs_entry_t            r_ent [RS_S];
  logic [RS_S-1:0]      w_busy, w_ready;
  logic [RS_ADD_W-1:0]  w_free_idx, w_rdy_idx;
  logic                 w_free_found, w_rdy_found;
  logic                 w_ins, w_issue;
  rs_cnt_t              w_free_cnt, w_free_after;
  rs_src_t              w_wk1 [RS_S];
  rs_src_t              w_wk2 [RS_S];
  rs_src_t              w_in1, w_in2;

  // Occupancy/readiness and per-entry wakeup candidates from the registered state.
  always_comb begin
    w_free_cnt = '0;
    for (int i = 0; i < RS_S; i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy && (r_ent[i].qs1 == '0) && (r_ent[i].qs2 == '0);
      if (!r_ent[i].busy) w_free_cnt = w_free_cnt + rs_cnt_t'(1);
      w_wk1[i] = snoop(rs_src_t'{q: r_ent[i].qs1, v: r_ent[i].vs1},
                       iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd);
      w_wk2[i] = snoop(rs_src_t'{q: r_ent[i].qs2, v: r_ent[i].vs2},
                       iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd);
    end
  end

  rs_pick #(.N(RS_S), .W(RS_ADD_W)) u_free_pick (
    .i_vec  (~w_busy),
    .o_idx  (w_free_idx),
    .o_found(w_free_found)
  );

  rs_pick #(.N(RS_S), .W(RS_ADD_W)) u_rdy_pick (
    .i_vec  (w_ready),
    .o_idx  (w_rdy_idx),
    .o_found(w_rdy_found)
  );

  // Same-cycle forwarding of dispatched sources and post-cycle free count.
  always_comb begin
    w_in1 = snoop(rs_src_t'{q: iROB_Qs1, v: iROB_Vs1},
                  iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd);
    w_in2 = snoop(rs_src_t'{q: iROB_Qs2, v: iROB_Vs2},
                  iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd);
    // A dispatch with no free slot is dropped (upstream never does this).
    w_ins        = iROB_En && w_free_found;
    w_issue      = w_rdy_found;
    w_free_after = w_free_cnt + rs_cnt_t'(w_issue) - rs_cnt_t'(w_ins);
  end

  // Entry array: flush, wakeup, issue-clear and insert. The insert slot is
  // free in the registered state, so it never collides with wakeup or issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_S; i++) r_ent[i] <= '0;
    end else if (en) begin
      if (iMp) begin
        for (int i = 0; i < RS_S; i++) r_ent[i].busy <= 1'b0;
      end else begin
        for (int i = 0; i < RS_S; i++) begin
          if (r_ent[i].busy) begin
            r_ent[i].qs1 <= w_wk1[i].q;
            r_ent[i].vs1 <= w_wk1[i].v;
            r_ent[i].qs2 <= w_wk2[i].q;
            r_ent[i].vs2 <= w_wk2[i].v;
          end
        end
        if (w_issue) r_ent[w_rdy_idx].busy <= 1'b0;
        if (w_ins) begin
          r_ent[w_free_idx] <= rs_entry_t'{
            busy: 1'b1, op: iROB_Op, pc: iROB_Pc, imm: iROB_Imm,
            qs1: w_in1.q, qs2: w_in2.q, vs1: w_in1.v, vs2: w_in2.v,
            qd: iROB_Qd};
        end
      end
    end
  end

  // Issue port and fetch-stall flag; data holds when nothing issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oEX_En   <= 1'b0;
      oEX_Op   <= '0;
      oEX_Pc   <= '0;
      oEX_Imm  <= '0;
      oEX_Vs1  <= '0;
      oEX_Vs2  <= '0;
      oEX_Qd   <= '0;
      oIF_Full <= 1'b0;
    end else if (en) begin
      if (iMp) begin
        oEX_En   <= 1'b0;
        oIF_Full <= 1'b0;
      end else begin
        oEX_En   <= w_issue;
        oIF_Full <= (w_free_after <= rs_cnt_t'(FULL_MARGIN));
        if (w_issue) begin
          oEX_Op  <= r_ent[w_rdy_idx].op;
          oEX_Pc  <= r_ent[w_rdy_idx].pc;
          oEX_Imm <= r_ent[w_rdy_idx].imm;
          oEX_Vs1 <= r_ent[w_rdy_idx].vs1;
          oEX_Vs2 <= r_ent[w_rdy_idx].vs2;
          oEX_Qd  <= r_ent[w_rdy_idx].qd;
        end
      end
    end
  end
endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Reservation station for arithmetic, branch and jump instructions. It sits directly downstream of the ROB.
- Accepts operand-resolved or tag-pending instructions from the ROB dispatch port and snoops the EX and LSB result broadcasts for wakeup.
- Each cycle it issues at most one operand-ready instruction to the EX unit.
- Flushed by the ROB misprediction pulse.

Parameters:
RS_S, 16, number of station entries (power of two)
RS_ADD_W, 4, log2(RS_S)
FULL_MARGIN, 2, free-entry threshold for asserting oIF_Full (covers dispatch in flight)
REG_DAT_W, 32, data width (from header.vh)
ROB_ADD_W, 4, ROB tag width; tag 0 = "no dependency" (from header.vh)
INS_OP_W, 6, opcode width (from header.vh)

Ports:
clk  in  1  clock
rst  in  1  reset: asynchronous, active-low
en  in  1  global enable; low freezes all state and outputs
iMp  in  1  ROB misprediction flush pulse
iROB_En  in  1  dispatch valid
iROB_Op  in  INS_OP_W  opcode
iROB_Pc  in  REG_DAT_W  instruction PC
iROB_Imm  in  REG_DAT_W  immediate
iROB_Qs1/iROB_Qs2  in  ROB_ADD_W  source tags, 0 = value valid
iROB_Vs1/iROB_Vs2  in  REG_DAT_W  source values
iROB_Qd  in  ROB_ADD_W  destination ROB tag
iEX_En/iEX_Qd/iEX_Vd  in  1/ROB_ADD_W/REG_DAT_W  EX result broadcast
iLSB_En/iLSB_Qd/iLSB_Vd  in  1/ROB_ADD_W/REG_DAT_W  load result broadcast
oEX_En  out  1  issue pulse
oEX_Op/oEX_Pc/oEX_Imm/oEX_Vs1/oEX_Vs2/oEX_Qd  out  as inputs  issued instruction fields
oIF_Full  out  1  station nearly full; fetch must stall

Behaviour:
- **Entry contents:** busy, op, pc, imm, qs1, qs2, vs1, vs2, qd.
  - An entry is ready when busy, qs1 == 0 and qs2 == 0.
- **Reset (rst = 0, asynchronous):**
  - All busy flags are cleared.
  - All outputs go to 0, including oIF_Full = 0 and oEX_En = 0.
  - Asserting reset mid-operation discards all entries immediately.
- **en = 0:** no insert, no wakeup, no issue. Outputs hold, including oEX_En.
- **iMp = 1 (with en = 1):** synchronous flush with top priority.
  - All busy flags are cleared and oEX_En = 0 on the next cycle.
  - A same-cycle dispatch is discarded.
- **Insert:** on iROB_En, the new instruction is written into the lowest-index entry that is not busy in the registered state.
  - Same-cycle forwarding, applied per source independently:
    - If Qsx != 0 and iEX_En and iEX_Qd == Qsx, store vsx = iEX_Vd and qsx = 0.
    - Else if iLSB_En and iLSB_Qd == Qsx, store iLSB_Vd and qsx = 0.
    - Otherwise store the inputs unchanged.
  - Dispatch with no free entry: upstream guarantees this never happens; the bench flags it with an assertion and the RTL drops the instruction.
- **Wakeup:** for every busy entry, a source with qsx != 0 matching an enabled broadcast captures the value and sets qsx = 0. EX takes priority if both broadcasts match (legal tags never collide).
- **Select/issue:**
  - Each enabled cycle, the lowest-index ready entry in the registered state is chosen.
  - Its fields are registered to oEX_*, oEX_En = 1 for exactly one cycle, and the entry's busy flag is cleared.
  - oEX_* data holds its last value when oEX_En = 0.
- **Latency:**
  - Instruction dispatched ready at edge E0 has oEX_En high after edge E1.
  - Instruction woken at edge Ew has oEX_En high after Ew+1.
  - Woken values are never issued in the same cycle they are captured.
- **Simultaneous events:**
  - An entry freed by issue is not reusable by a same-cycle insert.
  - Insert, wakeup and issue are all allowed in the same cycle.
- **oIF_Full:** registered; equals 1 when the free-entry count after this cycle's insert and issue is ≤ FULL_MARGIN.

Decomposition:
- header.vh: add RS_S, RS_ADD_W and FULL_MARGIN. It already provides REG_DAT_W, ROB_ADD_W and INS_OP_W.
- Sub-module rs_pick: parameterised lowest-index-first priority encoder over an RS_S-bit vector, outputting index and found.
  - Instantiated twice: free-slot pick over ~busy, and ready pick.

Test Plan:
- Reset mid-run: fill 3 entries, drop rst for 1 ns -> oEX_En = 0 and oIF_Full = 0 immediately; no issue after release.
- Ready dispatch Qs1 = Qs2 = 0, Vs1 = 5, Vs2 = 7, Qd = 3, Op = 1 at E0 -> oEX_En = 1 after E1 with Vs1 = 5, Vs2 = 7, Qd = 3; low after E2.
- Wakeup: dispatch Qs1 = 4, Vs2 = 9; 3 cycles later iEX_En, Qd = 4, Vd = 0x10 -> issue next cycle with Vs1 = 0x10, Vs2 = 9.
- Same-cycle forward: dispatch Qs2 = 6 with iLSB_En, Qd = 6, Vd = 0xABCD that cycle -> issued after E1 with Vs2 = 0xABCD.
- Priority: entries 0 and 2 both pending on tag 5; broadcast tag 5 -> entry 0 issues first, entry 2 the following cycle.
- Full/flush: with FULL_MARGIN = 2, dispatch 14 non-ready entries -> oIF_Full = 1; issue one -> oIF_Full = 0; then pulse iMp -> all entries gone, no oEX_En even after matching broadcasts.
